// File: rtl/execute_stage_pkg.sv
// rtl/execute_stage_pkg.sv - shared encodings and EX/MEM record for the execute stage
package execute_stage_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_AND  = 4'b0010,
    ALU_OR   = 4'b0011,
    ALU_SLL  = 4'b0100,
    ALU_SLT  = 4'b0101,
    ALU_XOR  = 4'b0110,
    ALU_SRL  = 4'b0111,
    ALU_SLTU = 4'b1000,
    ALU_SRA  = 4'b1111
  } alu_op_e;

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

  typedef enum logic [2:0] {
    BR_EQ  = 3'b000,
    BR_NE  = 3'b001,
    BR_LT  = 3'b100,
    BR_GE  = 3'b101,
    BR_LTU = 3'b110,
    BR_GEU = 3'b111
  } br_funct3_e;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10
  } result_src_e;

  typedef struct packed {
    logic        reg_write;
    logic        mem_write;
    logic [1:0]  result_src;
    logic [4:0]  rd;
    logic [31:0] alu_result;
    logic [31:0] write_data;
    logic [31:0] pc_plus4;
  } exmem_t;

  // Unused select code 11 falls back to the register-file value.
  function automatic logic [31:0] fwd_mux(
    input logic [1:0]  sel,
    input logic [31:0] reg_val,
    input logic [31:0] wb_val,
    input logic [31:0] mem_val
  );
    logic [31:0] y;
    case (sel)
      FWD_WB:  y = wb_val;
      FWD_MEM: y = mem_val;
      default: y = reg_val;
    endcase
    return y;
  endfunction

endpackage

// File: rtl/execute_stage_if.sv
// rtl/execute_stage_if.sv - ID/EX inputs, hazard controls and EX/MEM outputs of the execute stage
interface execute_stage_if;

  logic        RegWriteE;
  logic        MemWriteE;
  logic [1:0]  ResultSrcE;
  logic        BranchE;
  logic        JumpE;
  logic        JalrE;
  logic        ALUSrcE;
  logic [3:0]  ALUControlE;
  logic [2:0]  Funct3E;

  logic [31:0] RD1_E;
  logic [31:0] RD2_E;
  logic [31:0] Imm_Ext_E;
  logic [31:0] PCE;
  logic [31:0] PCPlus4E;
  logic [4:0]  RD_E;
  logic [31:0] ResultW;
  logic [1:0]  ForwardA_E;
  logic [1:0]  ForwardB_E;

  logic        hold;
  logic        flush;

  logic        PCSrcE;
  logic [31:0] PCTargetE;

  logic        RegWriteM;
  logic        MemWriteM;
  logic [1:0]  ResultSrcM;
  logic [4:0]  RD_M;
  logic [31:0] ALUResultM;
  logic [31:0] WriteDataM;
  logic [31:0] PCPlus4M;

  modport master (
    output RegWriteE, MemWriteE, ResultSrcE, BranchE, JumpE, JalrE, ALUSrcE,
           ALUControlE, Funct3E, RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, RD_E,
           ResultW, ForwardA_E, ForwardB_E, hold, flush,
    input  PCSrcE, PCTargetE, RegWriteM, MemWriteM, ResultSrcM, RD_M,
           ALUResultM, WriteDataM, PCPlus4M
  );

  modport slave (
    input  RegWriteE, MemWriteE, ResultSrcE, BranchE, JumpE, JalrE, ALUSrcE,
           ALUControlE, Funct3E, RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, RD_E,
           ResultW, ForwardA_E, ForwardB_E, hold, flush,
    output PCSrcE, PCTargetE, RegWriteM, MemWriteM, ResultSrcM, RD_M,
           ALUResultM, WriteDataM, PCPlus4M
  );

endinterface

// File: rtl/execute_stage_alu.sv
// rtl/execute_stage_alu.sv - combinational 32-bit integer ALU
module execute_stage_alu
  import execute_stage_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [3:0]  op,
  output logic [31:0] y
);

  logic [4:0] shamt;

  assign shamt = b[4:0];

  always_comb begin
    y = '0;
    case (op)
      ALU_ADD:  y = a + b;
      ALU_SUB:  y = a - b;
      ALU_AND:  y = a & b;
      ALU_OR:   y = a | b;
      ALU_XOR:  y = a ^ b;
      ALU_SLL:  y = a << shamt;
      ALU_SRL:  y = a >> shamt;
      ALU_SRA:  y = $unsigned($signed(a) >>> shamt);
      ALU_SLT:  y = {31'b0, $signed(a) < $signed(b)};
      ALU_SLTU: y = {31'b0, a < b};
      default:  y = '0;
    endcase
  end

endmodule

// File: rtl/execute_stage.sv
// rtl/execute_stage.sv - RISC-V execute stage: forwarding, ALU, branch resolve, EX/MEM register
module execute_stage
  import execute_stage_pkg::*;
(
  input logic            clk,
  input logic            rst,
  execute_stage_if.slave ex
);

  logic [31:0] src_a;
  logic [31:0] rs2_fwd;
  logic [31:0] src_b;
  logic [31:0] alu_result;
  logic [31:0] jalr_sum;
  logic [31:0] pc_rel;
  logic        br_eq;
  logic        br_lt;
  logic        br_ltu;
  logic        br_cond;
  exmem_t      exmem_d;
  exmem_t      exmem_q;

  // Memory-stage forwarding reads the register itself, so a held stage keeps supplying it.
  assign src_a   = fwd_mux(ex.ForwardA_E, ex.RD1_E, ex.ResultW, exmem_q.alu_result);
  assign rs2_fwd = fwd_mux(ex.ForwardB_E, ex.RD2_E, ex.ResultW, exmem_q.alu_result);
  assign src_b   = ex.ALUSrcE ? ex.Imm_Ext_E : rs2_fwd;

  execute_stage_alu ALU (
    .a  (src_a),
    .b  (src_b),
    .op (ex.ALUControlE),
    .y  (alu_result)
  );

  // Branches compare rs2 directly, never the immediate that may sit on the ALU B input.
  assign br_eq  = (src_a == rs2_fwd);
  assign br_lt  = ($signed(src_a) < $signed(rs2_fwd));
  assign br_ltu = (src_a < rs2_fwd);

  always_comb begin
    br_cond = 1'b0;
    case (ex.Funct3E)
      BR_EQ:   br_cond = br_eq;
      BR_NE:   br_cond = !br_eq;
      BR_LT:   br_cond = br_lt;
      BR_GE:   br_cond = !br_lt;
      BR_LTU:  br_cond = br_ltu;
      BR_GEU:  br_cond = !br_ltu;
      default: br_cond = 1'b0;
    endcase
  end

  assign ex.PCSrcE = (ex.BranchE & br_cond) | ex.JumpE;

  assign jalr_sum     = src_a + ex.Imm_Ext_E;
  assign pc_rel       = ex.PCE + ex.Imm_Ext_E;
  assign ex.PCTargetE = ex.JalrE ? (jalr_sum & ~32'd1) : pc_rel;

  always_comb begin
    exmem_d            = '0;
    exmem_d.reg_write  = ex.RegWriteE;
    exmem_d.mem_write  = ex.MemWriteE;
    exmem_d.result_src = ex.ResultSrcE;
    exmem_d.rd         = ex.RD_E;
    exmem_d.alu_result = alu_result;
    exmem_d.write_data = rs2_fwd;
    exmem_d.pc_plus4   = ex.PCPlus4E;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      exmem_q <= '0;
    end else if (ex.flush) begin
      exmem_q <= '0;
    end else if (!ex.hold) begin
      exmem_q <= exmem_d;
    end
  end

  assign ex.RegWriteM  = exmem_q.reg_write;
  assign ex.MemWriteM  = exmem_q.mem_write;
  assign ex.ResultSrcM = exmem_q.result_src;
  assign ex.RD_M       = exmem_q.rd;
  assign ex.ALUResultM = exmem_q.alu_result;
  assign ex.WriteDataM = exmem_q.write_data;
  assign ex.PCPlus4M   = exmem_q.pc_plus4;

endmodule

// File: doc/execute_stage.md
EXECUTE_STAGE -- requirements
Module: execute_stage

Interface
REQ-001 The block SHALL have one clock and a synchronous active-high reset; the ports are:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-high
REQ-002 The block SHALL provide these control inputs:
- RegWriteE  in  1  register-file write enable
- MemWriteE  in  1  store enable
- ResultSrcE  in  2  write-back select
- BranchE  in  1  conditional branch
- JumpE  in  1  jal/jalr
- JalrE  in  1  jalr target
- ALUSrcE  in  1  B operand: 0 = forwarded rs2, 1 = immediate
- ALUControlE  in  4  ALU operation code
- Funct3E  in  3  branch condition
REQ-003 The block SHALL provide these data inputs:
- RD1_E, RD2_E  in  32  register operands
- Imm_Ext_E  in  32  immediate
- PCE, PCPlus4E  in  32  PC values
- RD_E  in  5  destination register
- ResultW  in  32  write-back value for forwarding
- ForwardA_E, ForwardB_E  in  2  operand select: 00 = register, 01 = ResultW, 10 = ALUResultM
REQ-004 The block SHALL provide these pipeline-control inputs:
- hold  in  1  freeze the EX/MEM register
- flush  in  1  load a bubble into the EX/MEM register
REQ-005 The block SHALL provide these combinational outputs:
- PCSrcE  out  1  redirect fetch
- PCTargetE  out  32  redirect address
REQ-006 The block SHALL provide these registered outputs:
- RegWriteM, MemWriteM  out  1  MEM-stage controls
- ResultSrcM  out  2  MEM-stage write-back select
- RD_M  out  5  MEM-stage destination register
- ALUResultM, WriteDataM, PCPlus4M  out  32  MEM-stage data

Function
REQ-007 SrcA SHALL be RD1_E, ResultW or ALUResultM per ForwardA_E; code 11 SHALL select RD1_E.
REQ-008 The forwarded rs2 value SHALL be selected the same way per ForwardB_E; SrcB SHALL be Imm_Ext_E when ALUSrcE=1, else the forwarded rs2.
REQ-009 The ALU result SHALL be computed combinationally from SrcA, SrcB and ALUControlE. Encodings:
- add 0000, sub 0001, and 0010, or 0011, sll 0100, slt 0101
- xor 0110, srl 0111, sltu 1000, sra 1111
- all other codes give 0
- shift amount = SrcB[4:0]; all arithmetic modulo 2^32
REQ-010 The branch condition SHALL use a dedicated 32-bit comparator on SrcA and the forwarded rs2, not ALU flags:
- funct3 000 eq, 001 ne, 100 lt signed, 101 ge signed, 110 ltu, 111 geu
- 010 and 011 never taken
REQ-011 PCSrcE SHALL equal (BranchE AND condition) OR JumpE, combinationally, independent of hold/flush.
REQ-012 PCTargetE SHALL be the jump target:
- JalrE=1: (SrcA + Imm_Ext_E) with bit 0 cleared
- otherwise: PCE + Imm_Ext_E
- wrap modulo 2^32
REQ-013 On each rising edge, EX/MEM register priority SHALL be rst > flush > hold > load.
REQ-014 Load SHALL capture, one-cycle latency:
- control fields into the M outputs
- ALU result into ALUResultM
- forwarded rs2 (never the immediate) into WriteDataM
- PCPlus4E into PCPlus4M
REQ-015 Flush SHALL clear all registered outputs to 0 (bubble: no write, no store).
REQ-016 Hold SHALL keep all registered outputs unchanged; forwarding code 10 SHALL then keep supplying the held ALUResultM.
REQ-017 When flush and hold are both asserted, flush SHALL win.

Reset
REQ-018 While rst=1 at a rising edge, all registered outputs SHALL become 0 on that edge, regardless of flush/hold.
REQ-019 Reset SHALL NOT gate the combinational outputs; they follow the inputs and the (zeroed) ALUResultM.
REQ-020 Reset asserted mid-stream SHALL discard the in-flight EX/MEM contents; the first load after rst falls SHALL proceed normally.

Structure
REQ-021 A shared package SHALL hold:
- ALU control codes
- forward-select codes
- branch funct3 codes
- ResultSrc encodings
REQ-022 The ALU SHALL be one instantiated sub-module, ALU; muxes, comparator, target adder and EX/MEM register SHALL live in execute_stage.

Verification
REQ-023 Add with memory forward:
- cycle 1: RD1=5, Imm=7, ALUSrc=1, add -> next edge ALUResultM=12
- cycle 2: ForwardA=10, Imm=3 -> ALUResultM=15
REQ-024 Branch, signed vs unsigned:
- SrcA=0xFFFFFFFF, rs2=1, Funct3=100, BranchE=1 -> PCSrcE=1
- Funct3=110 -> PCSrcE=0
- PCE=0x100, Imm=0xFFFFFFF0 -> PCTargetE=0xF0
REQ-025 jalr: SrcA=0x1003, Imm=4, JalrE=1, JumpE=1 -> PCSrcE=1, PCTargetE=0x1006, PCPlus4M=PCPlus4E next edge.
REQ-026 Store path: ALUSrc=1, Imm=8, RD2=0xDEAD -> WriteDataM=0xDEAD, ALUResultM=RD1+8.
REQ-027 hold for 3 cycles -> outputs frozen; hold+flush together -> RegWriteM=0, MemWriteM=0, ALUResultM=0.
REQ-028 rst=1 mid-stream with RegWriteM=1 -> next edge all M outputs 0; after rst falls, first load proceeds normally.
